// File: rtl/shift_universal_register_pkg.sv
// Shared definitions for the universal shift register.
// Holds the shift-mode encoding and a helper that sizes the shift counter.
package shift_universal_register_pkg;

    // Shift / rotate mode encoding carried on i_mode.
    typedef enum logic [1:0] {
        SHIFT_SHL  = 2'b00,
        SHIFT_SHR  = 2'b01,
        SHIFT_ROTL = 2'b10,
        SHIFT_ROTR = 2'b11
    } shift_mode_e;

    // Counter width needed to hold values 0..words inclusive.
    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/shift_universal_register_if.sv
// Bus interface of the universal shift register.
// Control: i_sclr, i_load, i_en, i_mode. Data in: i_data (parallel), i_dat (serial).
// Data out: o_data (word), o_dat (serial out), o_cnt (shift count), o_done (full word moved).
// master = the side driving the controls, slave = the register itself.
interface shift_universal_register_if
    import shift_universal_register_pkg::*;
#(
    parameter int BITS = 8,
    parameter int STEP = 1
);
    localparam int WORDS = BITS / STEP;
    localparam int CNTW  = cnt_width(WORDS);

    logic            i_sclr;
    logic            i_load;
    logic [BITS-1:0] i_data;
    logic            i_en;
    logic [1:0]      i_mode;
    logic [STEP-1:0] i_dat;
    logic [BITS-1:0] o_data;
    logic [STEP-1:0] o_dat;
    logic [CNTW-1:0] o_cnt;
    logic            o_done;

    modport master (
        output i_sclr, i_load, i_data, i_en, i_mode, i_dat,
        input  o_data, o_dat, o_cnt, o_done
    );

    modport slave (
        input  i_sclr, i_load, i_data, i_en, i_mode, i_dat,
        output o_data, o_dat, o_cnt, o_done
    );

endinterface

// File: rtl/shift_universal_register_sat_counter.sv
// Saturating up-counter.
// Ports: clk, i_arst (async active-high reset), i_clr (sync clear, wins over i_inc),
// i_inc (count up, holds at MAX), o_cnt (registered count), o_max (o_cnt == MAX).
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             i_arst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_max
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] cnt_r;

    // Count register: clear has priority, increment stops at MAX.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (i_inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_cnt = cnt_r;
    assign o_max = (cnt_r == MAX_C);

endmodule

// File: rtl/shift_universal_register.sv
// Universal shift register: parallel load plus shift/rotate left/right by STEP bits.
// Ports: clk, i_arst (async active-high reset), bus (slave modport carrying
// i_sclr, i_load, i_data, i_en, i_mode, i_dat, o_data, o_dat, o_cnt, o_done).
// BITS must be a multiple of STEP; o_done rises once BITS/STEP shifts have
// happened since the last load or clear and stays high while saturated.
module shift_universal_register
    import shift_universal_register_pkg::*;
#(
    parameter int BITS = 8,
    parameter int STEP = 1
) (
    input  logic                        clk,
    input  logic                        i_arst,
    shift_universal_register_if.slave   bus
);

    localparam int WORDS = BITS / STEP;
    localparam int CNTW  = cnt_width(WORDS);

    logic [BITS-1:0] data_r;
    logic [BITS-1:0] data_nxt_s;
    logic [BITS-1:0] shl_s;
    logic [BITS-1:0] shr_s;
    logic [BITS-1:0] rotl_s;
    logic [BITS-1:0] rotr_s;
    logic [STEP-1:0] dat_out_s;
    logic [CNTW-1:0] cnt_s;
    logic            done_s;
    shift_mode_e     mode_s;

    assign mode_s = shift_mode_e'(bus.i_mode);

    // When one step is the whole word, shifts replace the word with the serial
    // input and rotates are a no-op; the general slices would be empty.
    generate
        if (STEP == BITS) begin : g_full_step
            assign shl_s  = bus.i_dat;
            assign shr_s  = bus.i_dat;
            assign rotl_s = data_r;
            assign rotr_s = data_r;
        end else begin : g_part_step
            assign shl_s  = {data_r[BITS-STEP-1:0], bus.i_dat};
            assign shr_s  = {bus.i_dat, data_r[BITS-1:STEP]};
            assign rotl_s = {data_r[BITS-STEP-1:0], data_r[BITS-1 -: STEP]};
            assign rotr_s = {data_r[STEP-1:0], data_r[BITS-1:STEP]};
        end
    endgenerate

    // Next-word select: clear > load > shift > hold. Rotates never see i_dat.
    always_comb begin
        data_nxt_s = data_r;
        if (bus.i_sclr) begin
            data_nxt_s = {BITS{1'b0}};
        end else if (bus.i_load) begin
            data_nxt_s = bus.i_data;
        end else if (bus.i_en) begin
            case (mode_s)
                SHIFT_SHL:  data_nxt_s = shl_s;
                SHIFT_SHR:  data_nxt_s = shr_s;
                SHIFT_ROTL: data_nxt_s = rotl_s;
                SHIFT_ROTR: data_nxt_s = rotr_s;
                default:    data_nxt_s = data_r;
            endcase
        end else begin
            data_nxt_s = data_r;
        end
    end

    // Data word register.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            data_r <= {BITS{1'b0}};
        end else begin
            data_r <= data_nxt_s;
        end
    end

    // Serial output: the bits that leave on the next shift in the current mode.
    always_comb begin
        dat_out_s = data_r[BITS-1 -: STEP];
        case (mode_s)
            SHIFT_SHL, SHIFT_ROTL: dat_out_s = data_r[BITS-1 -: STEP];
            SHIFT_SHR, SHIFT_ROTR: dat_out_s = data_r[STEP-1:0];
            default:               dat_out_s = data_r[BITS-1 -: STEP];
        endcase
    end

    // Loads and clears restart the count; the counter itself ranks clear over increment.
    sat_counter #(
        .WIDTH (CNTW),
        .MAX   (WORDS)
    ) u_sat_counter (
        .clk    (clk),
        .i_arst (i_arst),
        .i_clr  (bus.i_sclr | bus.i_load),
        .i_inc  (bus.i_en),
        .o_cnt  (cnt_s),
        .o_max  (done_s)
    );

    assign bus.o_data = data_r;
    assign bus.o_dat  = dat_out_s;
    assign bus.o_cnt  = cnt_s;
    assign bus.o_done = done_s;

endmodule

// File: doc/shift_universal_register.md
Name: shift_universal_register

Overview:
Parametrised successor to the single-bit left-shift register. Holds a BITS-wide word and supports parallel load plus shift-left, shift-right, rotate-left and rotate-right by STEP bits per enabled cycle. Tracks the number of shifts since the last load or clear and flags when a full word has moved. Used as serialiser (load, then shift out) or deserialiser (shift in, then read o_data) in the VGA/general datapath.

Parameters:
BITS, 8, register width in bits; must be a multiple of STEP.
STEP, 1, bits moved per shift; 1 <= STEP <= BITS.
Derived localparam WORDS = BITS/STEP, the shift count for a full word.
Derived localparam CNTW = clog2(WORDS+1), the counter width.

Ports:
clk  in  1  rising-edge clock.
i_arst  in  1  asynchronous active-high reset.
i_sclr  in  1  synchronous clear.
i_load  in  1  parallel load of i_data.
i_data  in  BITS  parallel load value.
i_en  in  1  shift enable.
i_mode  in  2  00 shl, 01 shr, 10 rotl, 11 rotr.
i_dat  in  STEP  serial input; unused in rotate modes.
o_data  out  BITS  register contents.
o_dat  out  STEP  serial output: the bits leaving on the next shift.
o_cnt  out  CNTW  shifts since last load or clear; saturating.
o_done  out  1  high when o_cnt == WORDS.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high on i_arst.
- i_arst asserted: o_data=0, o_cnt=0 and o_done=0 immediately, with no clock edge needed. Deassertion takes effect at the next clk edge.
- Priority at each clk rising edge: i_sclr > i_load > i_en > hold.
- i_sclr: o_data<=0, o_cnt<=0.
- i_load: o_data<=i_data, o_cnt<=0.
- i_en, per i_mode (all modes: o_cnt<=min(o_cnt+1, WORDS)):
  - shl: o_data<={o_data[BITS-STEP-1:0], i_dat}.
  - shr: o_data<={i_dat, o_data[BITS-1:STEP]}.
  - rotl: o_data<={o_data[BITS-STEP-1:0], o_data[BITS-1 -: STEP]}.
  - rotr: o_data<={o_data[STEP-1:0], o_data[BITS-1:STEP]}.
- Special case STEP==BITS:
  - shl/shr: o_data<=i_dat.
  - rot: o_data unchanged.
- Hold (no i_sclr, i_load or i_en): o_data and o_cnt are unchanged.
- Latency: one cycle from the enabling edge to o_data and o_cnt.
- o_dat is combinational from the current o_data and i_mode:
  - shl and rotl: o_data[BITS-1 -: STEP].
  - shr and rotr: o_data[STEP-1:0].
- o_done is combinational (o_cnt==WORDS) and stays high while saturated. Further shifts still move data.
- i_mode may change on any cycle. Only its value at the enabling edge matters.
- Unknown i_dat in rotate modes must not propagate into o_data.
- i_arst mid-shift sequence aborts it; the counter restarts from 0.

Decomposition:
- Shared header/package shift_pkg holds the mode constants: SHIFT_SHL=2'b00, SHIFT_SHR=2'b01, SHIFT_ROTL=2'b10, SHIFT_ROTR=2'b11.
- The existing assert/dump/clock testbench macros are reused unchanged.
- One natural sub-module, sat_counter: parameters WIDTH and MAX; inputs clk, i_arst, i_clr, i_inc; outputs o_cnt and o_max. It drives o_cnt and o_done.
- The data path stays in the top module.

Test Plan:
1. BITS=8, STEP=1: load 8'hFF, then pulse i_arst between edges → o_data=0, o_cnt=0, o_done=0 before the next clk edge.
2. BITS=8, STEP=1, shl after i_sclr, i_dat sequence 1,0,1,1 → o_data 8'h01, 8'h02, 8'h05, 8'h0B; o_cnt 1,2,3,4.
3. BITS=8, STEP=1, each case starting from a load of 8'hA5:
   - shr with i_dat=0 → 8'h52.
   - rotr → 8'hD2.
   - rotl → 8'h4B.
   - rotl with i_dat=X → 8'h4B, with no X in o_data.
4. BITS=8, STEP=2, deserialiser: load 0, then shl with i_dat 2'b10, 01, 11, 00 → o_data=8'b10011100.
   - o_done=1 after the 4th edge.
   - A 5th shift keeps o_cnt=4 and o_done=1.
5. BITS=8, STEP=1, serialiser: load 8'hC3, shl.
   - Before each of 8 shifts, o_dat reads 1,1,0,0,0,0,1,1.
   - o_done=1 after the 8th shift.
6. BITS=8, STEP=1, priority:
   - i_load=1 and i_en=1 together with i_data=8'h3C → o_data=8'h3C, o_cnt=0.
   - i_sclr=1 and i_load=1 together → o_data=0, o_cnt=0.
   - i_en=0 for 3 cycles → o_data and o_cnt unchanged.
